// File: rtl/bus_handoff.sv
// Two-entry registered valid/ready buffer with a skid register that cuts the ready path.
// Optional transfer counter on xfer_count when BUS_HANDOFF_COUNT_EN is defined.
//
// state | meaning
// EMPTY | no word held, out_valid low
// ONE   | out_reg holds the presented word
// FULL  | out_reg presented, skid_reg holds the next word, in_ready low
module bus_handoff #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [BUS_WIDTH-1:0] out_data,
  input  logic                 out_ready
`ifdef BUS_HANDOFF_COUNT_EN
  ,
  output logic [15:0]          xfer_count
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [BUS_WIDTH-1:0] out_reg;
  logic [BUS_WIDTH-1:0] skid_reg;
  logic                 accept;
  logic                 take;

  assign out_valid = (state != EMPTY);
  assign out_data  = out_reg;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (accept) next_state = ONE;
      ONE: begin
        if (accept && !take)      next_state = FULL;
        else if (take && !accept) next_state = EMPTY;
      end
      FULL: if (take) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  // in_ready is registered from next_state so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
      case (state)
        EMPTY: if (accept) out_reg <= in_data;
        ONE: begin
          if (accept && take) out_reg  <= in_data;
          else if (accept)    skid_reg <= in_data;
        end
        FULL: if (take) out_reg <= skid_reg;
        default: ;
      endcase
    end
  end

`ifdef BUS_HANDOFF_COUNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                      cnt <= '0;
    else if (take && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end

  assign xfer_count = cnt;
`endif

endmodule

// File: tb/tb_bus_handoff.sv
// Self-checking bench for bus_handoff: directed vector table, randomized traffic
// against a queue-based reference model, and counter saturation when enabled.
module tb_bus_handoff;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [15:0] xfer_count;

  int vectors;
  int miscompares;

  bus_handoff #(.BUS_WIDTH(8)) dut (
`ifdef BUS_HANDOFF_COUNT_EN
    .xfer_count(xfer_count),
`endif
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready)
  );

`ifndef BUS_HANDOFF_COUNT_EN
  assign xfer_count = 16'h0000;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a FIFO of capacity two plus the word currently shown
  logic [7:0]  mq[$];
  logic [7:0]  m_shown;
  logic        m_ready;
  int unsigned m_cnt;

  task automatic model_edge(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    logic acc, tk;
    if (r) begin
      mq.delete();
      m_shown = 8'h00;
      m_ready = 1'b0;
      m_cnt   = 0;
    end else begin
      acc = iv & m_ready;
      tk  = (mq.size() > 0) & ordy;
      if (tk) begin
        void'(mq.pop_front());
        if (m_cnt < 32'hFFFF) m_cnt++;
      end
      if (acc) mq.push_back(d);
      if (mq.size() > 0) m_shown = mq[0];
      m_ready = (mq.size() < 2);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    reset     = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
    model_edge(r, iv, d, ordy);
  endtask

  task automatic chk_model();
    chk("model in_ready", {31'b0, in_ready}, {31'b0, m_ready});
    chk("model out_valid", {31'b0, out_valid}, {31'b0, (mq.size() > 0)});
    chk("model out_data", {24'b0, out_data}, {24'b0, m_shown});
`ifdef BUS_HANDOFF_COUNT_EN
    chk("model xfer_count", {16'b0, xfer_count}, m_cnt);
`endif
  endtask

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       eir;
    logic       eov;
    logic [7:0] eod;
    int         ecnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b0;
    m_shown     = 8'h00;
    m_ready     = 1'b0;
    m_cnt       = 0;

    // reset release
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    // streaming with out_ready high
    tbl[2]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 0};
    tbl[3]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1};
    tbl[4]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 2};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 3};
    // backpressure fills skid, FF ignored while full
    tbl[6]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 3};
    tbl[7]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hA5, 3};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 3};
    tbl[9]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 3};
    tbl[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA5, 3};
    tbl[11] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h5A, 4};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 5};
    // reset while full discards both words
    tbl[13] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 5};
    tbl[14] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hC3, 5};
    tbl[15] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].eir});
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].eov});
      chk($sformatf("vec%0d out_data", i), {24'b0, out_data}, {24'b0, tbl[i].eod});
`ifdef BUS_HANDOFF_COUNT_EN
      chk($sformatf("vec%0d xfer_count", i), {16'b0, xfer_count}, tbl[i].ecnt);
`endif
      chk_model();
    end

    // stability: out_data must not move while presented and not taken
    step(1'b0, 1'b1, 8'h9E, 1'b0);
    chk_model();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      chk("hold out_data", {24'b0, out_data}, 32'h9E);
    end

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 149) == 0), 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      chk_model();
    end

`ifdef BUS_HANDOFF_COUNT_EN
    // saturation: one take per cycle for more than 65535 cycles
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 8'(i), 1'b1);
    chk("sat xfer_count", {16'b0, xfer_count}, 32'hFFFF);
    chk_model();
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("sat no wrap", {16'b0, xfer_count}, 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_handoff.md
# bus_handoff

Two-entry registered valid/ready buffer that carries a BUS_WIDTH-bit word from a producer to a consumer and holds it stable until the consumer takes it. It is the consumer-facing complement to the enable-latched capture registers in the RC4 datapath: where those sample a bus on demand, this block presents a held word and releases it only on handshake. It sits between the keystream/decrypt stages and the result-memory writer, cutting the combinational ready path with a skid register.

## Interface
- BUS_WIDTH, 8, data word width in bits
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  producer has a word on in_data
- in_data  input  BUS_WIDTH  producer word
- in_ready  output  1  block can accept a word this cycle (registered)
- out_valid  output  1  out_data holds a valid word (registered)
- out_data  output  BUS_WIDTH  word presented to consumer (registered)
- out_ready  input  1  consumer takes out_data this cycle
- xfer_count  output  16  output transfers completed (only with BUS_HANDOFF_COUNT_EN)

## Operation
- Accept: in_valid & in_ready at a rising edge. Take: out_valid & out_ready at a rising edge.
- Storage: out_reg (drives out_data), skid_reg. State: EMPTY, ONE (out_reg valid), FULL (both valid).
- EMPTY: accept -> out_reg=in_data, ONE. No accept -> stay.
- ONE: accept & take -> out_reg=in_data, stay ONE. Accept only -> skid_reg=in_data, FULL. Take only -> EMPTY. Neither -> hold.
- FULL: in_ready=0, no accept possible. Take -> out_reg=skid_reg, ONE. No take -> hold both.
- out_valid = (state != EMPTY). in_ready is a flop loaded with (next_state != FULL).
- Words leave in acceptance order; no word dropped or duplicated.
- out_data unchanged while out_valid=1 and out_ready=0 (stability rule). out_data keeps last value after EMPTY.
- in_data is ignored whenever in_ready=0, regardless of in_valid.
- Reset (any cycle, mid-transfer included): state=EMPTY, out_valid=0, in_ready=0, out_data=0, skid_reg=0, xfer_count=0; pending words discarded. Accept/take coincident with reset has no effect.

## Timing
- in_ready: 0 during reset, 1 from first rising edge with reset low.
- Latency: word accepted at edge N is on out_data with out_valid=1 after edge N.
- Throughput: one word per cycle sustained while out_ready=1.
- Backpressure: out_ready low for 2+ cycles with in_valid high -> second word goes to skid_reg, in_ready drops after that edge; in_ready returns 1 after the edge of the next take.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

## Configuration
- BUS_HANDOFF_COUNT_EN defined: xfer_count port present; increments by 1 on every take, saturates at 16'hFFFF, reset to 0.
- Not defined: xfer_count port and counter absent; all other behaviour identical.

## Test plan
- Reset release, BUS_WIDTH=8: in_ready=0 in the first cycle after release, 1 thereafter; out_valid=0, out_data=8'h00.
- Stream 8'h11,8'h22,8'h33 with out_ready=1: each appears one cycle after acceptance, in order, in_ready stays 1, count=3.
- Accept 8'hA5, 8'h5A with out_ready=0: in_ready=0 after second accept, out_data=8'hA5 held; raise out_ready -> 8'hA5 then 8'h5A, in_ready=1 after first take.
- FULL with in_valid=1, in_data=8'hFF for 3 cycles: 8'hFF never appears on out_data.
- Reset asserted in FULL: next cycle out_valid=0, out_data=0, in_ready=0; both words lost.
- COUNT_EN, preload via 65537 takes: xfer_count=16'hFFFF, no wrap.
